// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int          DEF_ADDR_LEN = 32;
    localparam int          DEF_INST_LEN = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        VALID,
        HALT
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_sel_e;

endpackage

// File: rtl/pc_next.sv
// Next fetch-PC mux (hold / +4 / redirect) and the pc+4 adder for the presented instruction.
// FETCH_MISALIGN_CHK_EN: redirect targets are loaded unmodified instead of word-aligned.
module pc_next
    import fetch_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN
) (
    input  logic [ADDR_LEN-1:0] fetch_pc_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [ADDR_LEN-1:0] target_i,
    input  pc_sel_e             sel_i,
    output logic [ADDR_LEN-1:0] next_pc_o,
    output logic [ADDR_LEN-1:0] pc_plus4_o
);

    logic [ADDR_LEN-1:0] loadTarget;

`ifdef FETCH_MISALIGN_CHK_EN
    assign loadTarget = target_i;
`else
    // Without the checker a misaligned target is silently rounded down to a word.
    assign loadTarget = target_i & ~ADDR_LEN'(3);
`endif

    assign pc_plus4_o = pc_i + ADDR_LEN'(PC_STEP);

    always_comb begin
        next_pc_o = fetch_pc_i;
        case (sel_i)
            PC_INC:  next_pc_o = fetch_pc_i + ADDR_LEN'(PC_STEP);
            PC_LOAD: next_pc_o = loadTarget;
            default: next_pc_o = fetch_pc_i;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word request to instruction memory, presents instr/pc to decode.
// FETCH_MISALIGN_CHK_EN: misaligned redirect raises sticky misalign_err and halts fetch until rst.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  ADDR_LEN = DEF_ADDR_LEN,
    parameter int                  INST_LEN = DEF_INST_LEN,
    parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(DEF_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_target,
    output logic                instr_valid,
    output logic [INST_LEN-1:0] instr,
    output logic [ADDR_LEN-1:0] pc,
    output logic [ADDR_LEN-1:0] pc_plus4,
    output logic                misalign_err
);

    fetch_state_e        state_q, state_d;
    pc_sel_e             pcSel;
    logic [ADDR_LEN-1:0] fetchPc_q, fetchPc_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [INST_LEN-1:0] instr_q, instr_d;
    logic                instrValid_q, instrValid_d;
    logic                kill_q, kill_d;

    pc_next #(
        .ADDR_LEN(ADDR_LEN)
    ) u_pc_next (
        .fetch_pc_i(fetchPc_q),
        .pc_i      (pc_q),
        .target_i  (redirect_target),
        .sel_i     (pcSel),
        .next_pc_o (fetchPc_d),
        .pc_plus4_o(pc_plus4)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;
    logic badTarget;

    assign badTarget = redirect_valid && (redirect_target[1:0] != 2'b00) && (state_q != HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (badTarget) begin
            misalign_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q    <= RESET_PC;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            instrValid_q <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instrValid_q <= instrValid_d;
            kill_q       <= kill_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pcSel        = PC_HOLD;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instrValid_d = instrValid_q;
        kill_d       = kill_q;
        case (state_q)
            REQ: begin
                if (redirect_valid) pcSel = PC_LOAD;
                // Accepted together with a redirect: the old address is in flight, so its word must die.
                if (imem_req_ready) begin
                    state_d = WAIT;
                    kill_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) pcSel = PC_LOAD;
                if (imem_rsp_valid) begin
                    kill_d  = 1'b0;
                    state_d = REQ;
                    if (!(kill_q || redirect_valid)) begin
                        state_d      = VALID;
                        instr_d      = imem_rsp_data;
                        pc_d         = fetchPc_q;
                        instrValid_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    pcSel        = PC_LOAD;
                    instrValid_d = 1'b0;
                    state_d      = REQ;
                end else if (!stall) begin
                    pcSel        = PC_INC;
                    instrValid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        if (badTarget) begin
            state_d      = HALT;
            pcSel        = PC_HOLD;
            instrValid_d = 1'b0;
            kill_d       = 1'b0;
        end
`endif
    end

    always_comb begin
        imem_req_valid = (state_q == REQ) && !rst;
        imem_addr      = fetchPc_q;
        instr_valid    = instrValid_q;
        instr          = instr_q;
        pc             = pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_err   = misalign_q;
`else
        misalign_err   = 1'b0;
`endif
    end

endmodule
